// File: rtl/wb_regfile_writer_pkg.sv
// Shared definitions for the register-file writeback slice: default widths,
// the hardwired-zero register index, index/data typedefs and the debug tag
// that records which producer supplied the registered write.
package wb_pkg;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned REG_ZERO       = 0;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_EXU  = 2'd1,
    WB_SRC_LSU  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/wb_regfile_writer_if.sv
// Bundle of EXU/LSU result handshakes, commit stall, issue claim, scoreboard
// queries and the registered register-file write port.
//   master : writeback block (drives readies, busy flags, wen/waddr/wdata)
//   slave  : surrounding pipeline / register file
// Optional macro WB_BYPASS_EN adds rs1/rs2 forwarding hit and data signals.
interface wb_regfile_writer_if #(
  parameter int unsigned ADDR_WIDTH = wb_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = wb_pkg::DEF_DATA_WIDTH
);
  import wb_pkg::*;

  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  commit_stall;
  logic                  iss_valid;
  logic                  iss_ready;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  wb_src_e               wb_src;
`ifdef WB_BYPASS_EN
  logic                  rs1_fwd_hit;
  logic [DATA_WIDTH-1:0] rs1_fwd_data;
  logic                  rs2_fwd_hit;
  logic [DATA_WIDTH-1:0] rs2_fwd_data;
`endif

  modport master (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  commit_stall, iss_valid, iss_rd, rs1_addr, rs2_addr,
    output exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
    output wen, waddr, wdata, wb_src
`ifdef WB_BYPASS_EN
    , output rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data
`endif
  );

  modport slave (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output commit_stall, iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  exu_ready, lsu_ready, iss_ready, rs1_busy, rs2_busy,
    input  wen, waddr, wdata, wb_src
`ifdef WB_BYPASS_EN
    , input rs1_fwd_hit, rs1_fwd_data, rs2_fwd_hit, rs2_fwd_data
`endif
  );
endinterface

// File: rtl/wb_regfile_writer_scoreboard.sv
// Per-register busy scoreboard. Bit 0 is hardwired clear.
//   clk_i/rst_ni          : clock, async active-low reset
//   set_en_i/set_idx_i    : claim a destination (new producer)
//   clr_en_i/clr_idx_i    : release on the register-file write edge
//   rs1/rs2_addr_i, iss_rd_i : query indices
//   rs1/rs2_busy_o, iss_busy_o : busy state of the queried indices
module wb_scoreboard #(
  parameter int unsigned ADDR_WIDTH = wb_pkg::DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_idx_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_idx_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] iss_rd_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  iss_busy_o
);
  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-edge claim of the register being
  // written keeps it busy for the new producer.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_comb begin
    rs1_busy_o = busy_q[rs1_addr_i];
    rs2_busy_o = busy_q[rs2_addr_i];
    iss_busy_o = busy_q[iss_rd_i];
  end
endmodule

// File: rtl/wb_regfile_writer.sv
// Writeback initiator: arbitrates LSU (priority) and EXU results into one
// registered register-file write per cycle and tracks pending writes in a
// busy scoreboard for issue-stage hazard checks.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : wb_regfile_writer_if.master (result handshakes, stall, issue
//           claim, scoreboard queries, wen/waddr/wdata, debug source tag)
// Optional macro WB_BYPASS_EN: forwarding hit/data for rs1/rs2 from the
// in-flight write, masking the matching busy flag.
module wb_regfile_writer
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  wb_regfile_writer_if.master  bus
);
  logic                  lsu_fire, exu_fire, claim;
  logic                  iss_busy, rs1_busy_raw, rs2_busy_raw;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  wb_src_e               src_q, src_d;

  always_comb begin
    bus.lsu_ready = !bus.commit_stall;
    bus.exu_ready = !bus.commit_stall && !bus.lsu_valid;
    bus.iss_ready = !bus.commit_stall && !iss_busy;
    lsu_fire      = bus.lsu_valid && bus.lsu_ready;
    exu_fire      = bus.exu_valid && bus.exu_ready;
    claim         = bus.iss_valid && bus.iss_ready &&
                    (bus.iss_rd != ADDR_WIDTH'(REG_ZERO));
  end

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    src_d   = WB_SRC_NONE;
    if (lsu_fire) begin
      wen_d   = (bus.lsu_rd != ADDR_WIDTH'(REG_ZERO));
      waddr_d = bus.lsu_rd;
      wdata_d = bus.lsu_data;
      src_d   = WB_SRC_LSU;
    end else if (exu_fire) begin
      wen_d   = (bus.exu_rd != ADDR_WIDTH'(REG_ZERO));
      waddr_d = bus.exu_rd;
      wdata_d = bus.exu_data;
      src_d   = WB_SRC_EXU;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      src_q   <= WB_SRC_NONE;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
    end
  end

  wb_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk_i      (clock),
    .rst_ni     (reset),
    .set_en_i   (claim),
    .set_idx_i  (bus.iss_rd),
    .clr_en_i   (wen_q),
    .clr_idx_i  (waddr_q),
    .rs1_addr_i (bus.rs1_addr),
    .rs2_addr_i (bus.rs2_addr),
    .iss_rd_i   (bus.iss_rd),
    .rs1_busy_o (rs1_busy_raw),
    .rs2_busy_o (rs2_busy_raw),
    .iss_busy_o (iss_busy)
  );

  always_comb begin
    bus.wen    = wen_q;
    bus.waddr  = waddr_q;
    bus.wdata  = wdata_q;
    bus.wb_src = src_q;
`ifdef WB_BYPASS_EN
    bus.rs1_fwd_hit  = wen_q && (waddr_q == bus.rs1_addr) &&
                       (bus.rs1_addr != ADDR_WIDTH'(REG_ZERO));
    bus.rs2_fwd_hit  = wen_q && (waddr_q == bus.rs2_addr) &&
                       (bus.rs2_addr != ADDR_WIDTH'(REG_ZERO));
    bus.rs1_fwd_data = wdata_q;
    bus.rs2_fwd_data = wdata_q;
    bus.rs1_busy     = rs1_busy_raw && !bus.rs1_fwd_hit;
    bus.rs2_busy     = rs2_busy_raw && !bus.rs2_fwd_hit;
`else
    bus.rs1_busy     = rs1_busy_raw;
    bus.rs2_busy     = rs2_busy_raw;
`endif
  end
endmodule

// File: tb/tb_wb_regfile_writer.sv
module tb_wb_regfile_writer;
  import wb_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

`ifdef WB_BYPASS_EN
  localparam logic BUSY_DURING_WEN = 1'b0;
`else
  localparam logic BUSY_DURING_WEN = 1'b1;
`endif

  wb_regfile_writer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  wb_regfile_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.commit_stall = 1'b0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL rst_wen got=%0b exp=0", bus.wen); end
    checks++; if (bus.waddr !== 5'd0) begin failures++; $display("FAIL rst_waddr got=%0d exp=0", bus.waddr); end
    checks++; if (bus.wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.wdata); end
    checks++; if ({bus.lsu_ready, bus.exu_ready, bus.iss_ready} !== 3'b111) begin
      failures++; $display("FAIL rst_readies got=%b exp=111", {bus.lsu_ready, bus.exu_ready, bus.iss_ready}); end
    #6 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exu_write();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.exu_ready !== 1'b1) begin failures++; $display("FAIL exu_ready got=%0b exp=1", bus.exu_ready); end
    checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL exu_no_comb_wen got=%0b exp=0", bus.wen); end
    tick();
    bus.exu_valid = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++; $display("FAIL exu_write got=%0b/%0d/%h exp=1/5/deadbeef", bus.wen, bus.waddr, bus.wdata); end
    checks++; if (bus.wb_src !== WB_SRC_EXU) begin failures++; $display("FAIL exu_src got=%0d exp=%0d", bus.wb_src, WB_SRC_EXU); end
    tick();
    checks++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      failures++; $display("FAIL exu_after got=%0b/%0d/%h exp=0/5/deadbeef", bus.wen, bus.waddr, bus.wdata); end
  endtask

  task automatic test_collision();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h11;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd4; bus.exu_data = 32'h22;
    #1;
    checks++; if ({bus.lsu_ready, bus.exu_ready} !== 2'b10) begin
      failures++; $display("FAIL coll_readies got=%b exp=10", {bus.lsu_ready, bus.exu_ready}); end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd3, 32'h11}) begin
      failures++; $display("FAIL coll_lsu_write got=%0b/%0d/%h exp=1/3/11", bus.wen, bus.waddr, bus.wdata); end
    checks++; if (bus.wb_src !== WB_SRC_LSU) begin failures++; $display("FAIL coll_src got=%0d exp=%0d", bus.wb_src, WB_SRC_LSU); end
    checks++; if (bus.exu_ready !== 1'b1) begin failures++; $display("FAIL coll_exu_ready2 got=%0b exp=1", bus.exu_ready); end
    tick();
    bus.exu_valid = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd4, 32'h22}) begin
      failures++; $display("FAIL coll_exu_write got=%0b/%0d/%h exp=1/4/22", bus.wen, bus.waddr, bus.wdata); end
    tick();
    checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL coll_idle got=%0b exp=0", bus.wen); end
  endtask

  task automatic test_x0();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'h55;
    #1;
    checks++; if (bus.exu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", bus.exu_ready); end
    tick();
    bus.exu_valid = 1'b0;
    #1;
    checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL x0_wen got=%0b exp=0", bus.wen); end
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rs1_addr = 5'd0;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL x0_iss_ready got=%0b exp=1", bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL x0_busy got=%0b exp=0", bus.rs1_busy); end
  endtask

  task automatic test_scoreboard();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
    #1;
    checks++; if ({bus.iss_ready, bus.rs1_busy} !== 2'b10) begin
      failures++; $display("FAIL sb_claim1 got=%b exp=10", {bus.iss_ready, bus.rs1_busy}); end
    tick();
    checks++; if ({bus.iss_ready, bus.rs1_busy, bus.rs2_busy} !== 3'b011) begin
      failures++; $display("FAIL sb_claim2 got=%b exp=011", {bus.iss_ready, bus.rs1_busy, bus.rs2_busy}); end
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h77;
    tick();
    bus.exu_valid = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.rs1_busy, bus.iss_ready} !== {1'b1, 5'd7, BUSY_DURING_WEN, 1'b0}) begin
      failures++; $display("FAIL sb_wen_cycle got=%0b/%0d/%0b/%0b exp=1/7/%0b/0", bus.wen, bus.waddr, bus.rs1_busy, bus.iss_ready, BUSY_DURING_WEN); end
    tick();
    checks++; if ({bus.wen, bus.rs1_busy, bus.iss_ready} !== 3'b001) begin
      failures++; $display("FAIL sb_cleared got=%b exp=001", {bus.wen, bus.rs1_busy, bus.iss_ready}); end
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_data = 32'h78;
    tick();
    bus.exu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.iss_ready} !== {1'b1, 5'd7, 1'b1}) begin
      failures++; $display("FAIL sb_same_edge_pre got=%0b/%0d/%0b exp=1/7/1", bus.wen, bus.waddr, bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.rs1_busy} !== 2'b01) begin
      failures++; $display("FAIL sb_set_wins got=%b exp=01", {bus.wen, bus.rs1_busy}); end
  endtask

  task automatic test_stall();
    bus.commit_stall = 1'b1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hA5;
    bus.iss_rd = 5'd1;
    #1;
    checks++; if ({bus.lsu_ready, bus.exu_ready, bus.iss_ready} !== 3'b000) begin
      failures++; $display("FAIL stall_readies got=%b exp=000", {bus.lsu_ready, bus.exu_ready, bus.iss_ready}); end
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL stall_wen cyc=%0d got=%0b exp=0", i, bus.wen); end
    end
    bus.commit_stall = 1'b0;
    #1;
    checks++; if ({bus.lsu_ready, bus.wen} !== 2'b10) begin
      failures++; $display("FAIL stall_release got=%b exp=10", {bus.lsu_ready, bus.wen}); end
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd10, 32'hA5}) begin
      failures++; $display("FAIL stall_write got=%0b/%0d/%h exp=1/10/a5", bus.wen, bus.waddr, bus.wdata); end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hB6;
    tick();
    bus.lsu_valid = 1'b0;
    bus.commit_stall = 1'b1;
    #1;
    checks++; if ({bus.wen, bus.waddr, bus.wdata} !== {1'b1, 5'd11, 32'hB6}) begin
      failures++; $display("FAIL stall_inflight got=%0b/%0d/%h exp=1/11/b6", bus.wen, bus.waddr, bus.wdata); end
    tick();
    checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL stall_after got=%0b exp=0", bus.wen); end
    bus.commit_stall = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h99;
    tick();
    bus.exu_valid = 1'b0;
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd7;
    #1;
    checks++; if ({bus.wen, bus.rs1_busy, bus.rs2_busy} !== {1'b1, BUSY_DURING_WEN, 1'b1}) begin
      failures++; $display("FAIL arst_pre got=%b exp=1%0b1", {bus.wen, bus.rs1_busy, bus.rs2_busy}, BUSY_DURING_WEN); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.wen, bus.rs1_busy, bus.rs2_busy} !== 3'b000) begin
      failures++; $display("FAIL arst_now got=%b exp=000", {bus.wen, bus.rs1_busy, bus.rs2_busy}); end
    bus.iss_rd = 5'd9;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL arst_iss_ready got=%0b exp=1", bus.iss_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_exu_write();
    test_collision();
    test_x0();
    test_scoreboard();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Writeback-side initiator for the CPU register file write port (`wen`/`waddr`/`wdata`), which writes on the clock edge.
- Arbitrates results from the EXU and the LSU and registers exactly one write per cycle.
- Keeps a per-register busy scoreboard so the issue stage can detect RAW/WAW hazards before reading `rs1`/`rs2`.
- Sits between the EXU/LSU result buses and the register file.

Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid  in  1  LSU load result valid.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU load data.
- commit_stall  in  1  hold writeback (debug/difftest freeze).
- iss_valid  in  1  issue stage requests to claim iss_rd.
- iss_ready  out  1  claim granted.
- iss_rd  in  ADDR_WIDTH  destination to mark busy.
- rs1_addr  in  ADDR_WIDTH  scoreboard query 1.
- rs2_addr  in  ADDR_WIDTH  scoreboard query 2.
- rs1_busy  out  1  rs1_addr has a pending write.
- rs2_busy  out  1  rs2_addr has a pending write.
- wen  out  1  register-file write enable (registered).
- waddr  out  ADDR_WIDTH  register-file write address (registered).
- wdata  out  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset (async, reset=0):
  - wen=0, waddr=0, wdata=0.
  - All busy bits cleared.
  - Readies are combinational from cleared state: lsu_ready=1, exu_ready=1, iss_ready=1 (unless commit_stall).
- Arbitration, fixed priority LSU > EXU:
  - lsu_ready = !commit_stall.
  - exu_ready = !commit_stall && !lsu_valid.
  - A transfer occurs on valid&&ready at the rising edge.
- Write register, one-cycle latency:
  - On an accepted transfer, next cycle wen = (rd != 0), waddr = rd, wdata = data.
  - Otherwise wen = 0; waddr/wdata hold their previous values.
  - No combinational path from inputs to wen/waddr/wdata.
- x0 rule: a transfer to rd=0 is consumed and wen stays 0. x0 is never marked busy and never written.
- Scoreboard (busy[2**ADDR_WIDTH], bit 0 hardwired 0):
  - iss_ready = !commit_stall && !busy[iss_rd].
  - On iss_valid && iss_ready && iss_rd != 0, set busy[iss_rd].
  - Clear busy[waddr] in the cycle wen=1, i.e. the register-file write edge.
  - The clear and the rf write land on the same edge, so reads after that edge see new data with busy=0.
- Simultaneous set and clear of the same index in one edge: set wins (new producer claimed).
- Busy query outputs:
  - rs1_busy = busy[rs1_addr]; rs2_busy = busy[rs2_addr]. Purely combinational from flops.
  - Index 0 always returns 0.
- Unclaimed write: a write to a non-busy rd is still performed, and its busy clear is a no-op.
- commit_stall=1:
  - No new transfers and no new claims.
  - A wen already registered still completes.
  - The next cycle's wen=0.
- Mid-operation reset: any in-flight write is dropped (wen=0 immediately, asynchronously). All busy bits clear.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, adds the following outputs:
  - rs1_fwd_hit = wen && waddr == rs1_addr && rs1_addr != 0, with rs1_fwd_data = wdata.
  - Same for rs2 (rs2_fwd_hit, rs2_fwd_data).
  - rsN_busy is suppressed (0) when rsN_fwd_hit=1, so a consumer can take data one cycle earlier.
- When undefined: these ports are absent and busy clears only at the write edge.

Decomposition:
- Package wb_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - Localparam REG_ZERO = 0.
  - Typedef reg_idx_t, word_t.
  - Enum wb_src_e {WB_SRC_NONE, WB_SRC_EXU, WB_SRC_LSU}, used for the registered source tag in debug.
- Sub-module wb_scoreboard:
  - Contains the busy vector, set/clear priority and query ports.
  - The top does arbitration and the write register.

Test Plan:
- Reset, then exu_valid=1, exu_rd=5, exu_data=0xDEADBEEF → exu_ready=1; next cycle wen=1, waddr=5, wdata=0xDEADBEEF; following cycle wen=0.
- Collision: lsu_valid=1/rd=3/0x11 and exu_valid=1/rd=4/0x22 in the same cycle → lsu_ready=1, exu_ready=0. Write 3←0x11, then next cycle 4←0x22.
- x0 write:
  - Transfer: exu_rd=0, data=0x55 → accepted, wen stays 0.
  - Claim: iss_rd=0 → rs1_busy with rs1_addr=0 stays 0.
- Scoreboard:
  - Claim iss_rd=7 → rs1_busy=1 for rs1_addr=7.
  - Second claim of 7 → iss_ready=0.
  - EXU write rd=7 → busy clears on the wen edge; iss_ready=1 again.
  - Same-edge claim of 7 while wen writes 7 → busy stays 1.
- commit_stall=1 with lsu_valid=1 → lsu_ready=0, no wen for the stall duration. Release → write occurs one cycle after acceptance.
- Async reset asserted mid-cycle with wen=1 and busy[9]=1 → wen=0 and busy[9]=0 immediately, without a clock edge.
